// File: rtl/dds_pkg.sv
// Shared definitions for the DDS configuration initiator: register map indices,
// FSM state encoding, latched register set and index helpers.
package dds_pkg;

    localparam logic [2:0] IDX_CTRL   = 3'd0;
    localparam logic [2:0] IDX_THETAS = 3'd1;
    localparam logic [2:0] IDX_DELTAS = 3'd2;
    localparam logic [2:0] IDX_AMPLS  = 3'd3;
    localparam logic [2:0] IDX_CLKDIV = 3'd4;
    localparam logic [2:0] IDX_STAT   = 3'd5;
    localparam logic [2:0] IDX_LNGTH  = 3'd6;

    typedef enum logic [2:0] {
        IDLE,
        WR_HALT,
        WR_REGS,
        WR_CTRL,
        RD_VERIFY,
        STAT_RD,
        STAT_RSP,
        DONE
    } state_t;

    typedef struct packed {
        logic [31:0] ctrl;
        logic [31:0] thetas;
        logic [31:0] deltas;
        logic [31:0] ampls;
        logic [31:0] clkdiv;
        logic [31:0] lngth;
    } cfg_regs_t;

    function automatic logic [31:0] reg_value(input cfg_regs_t r, input logic [2:0] idx);
        logic [31:0] v;
        case (idx)
            IDX_CTRL:   v = r.ctrl;
            IDX_THETAS: v = r.thetas;
            IDX_DELTAS: v = r.deltas;
            IDX_AMPLS:  v = r.ampls;
            IDX_CLKDIV: v = r.clkdiv;
            IDX_LNGTH:  v = r.lngth;
            default:    v = '0;
        endcase
        return v;
    endfunction

    // STAT is read-only, so the programming order hops from CLKDIV straight to LNGTH.
    function automatic logic [2:0] next_index(input logic [2:0] idx);
        return (idx == IDX_CLKDIV) ? IDX_LNGTH : idx + 3'd1;
    endfunction

endpackage

// File: rtl/dds_cfg_initiator.sv
// DDS register-map configuration initiator: halt, program, re-enable, optional
// readback verify (macro DDS_CFG_VERIFY_EN), plus single STAT readouts.
module dds_cfg_initiator
    import dds_pkg::*;
#(
    parameter int SIG_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_cfg_valid,
    output logic                 o_cfg_ready,
    input  logic [31:0]          i_cfg_ctrl,
    input  logic [31:0]          i_cfg_thetas,
    input  logic [31:0]          i_cfg_deltas,
    input  logic [31:0]          i_cfg_ampls,
    input  logic [31:0]          i_cfg_clkdiv,
    input  logic [31:0]          i_cfg_lngth,
    input  logic                 i_stat_req,
    output logic                 o_stat_valid,
    output logic [SIG_WIDTH-1:0] o_stat_data,
    output logic                 o_bus_write,
    output logic                 o_bus_read,
    output logic [31:0]          o_bus_addrs,
    output logic [31:0]          o_bus_writedata,
    input  logic [31:0]          i_bus_readdata,
    output logic                 o_done,
    output logic                 o_err
);

    state_t      state, state_d;
    logic [2:0]  idx, idx_d;
    cfg_regs_t   cfg_q, cfg_d;
    logic        accept;
    logic        bus_write_d, bus_read_d;
    logic [31:0] addrs_d, wdata_d;
    logic        unused_rd;

    assign o_cfg_ready = (state == IDLE);
    assign accept      = i_cfg_valid && o_cfg_ready;
    assign unused_rd   = &{1'b0, i_bus_readdata};

    // Bus strobes are derived from the next state so they line up with it once registered.
    always_comb begin
        state_d     = state;
        idx_d       = idx;
        cfg_d       = cfg_q;
        bus_write_d = 1'b0;
        bus_read_d  = 1'b0;
        addrs_d     = '0;
        wdata_d     = '0;

        if (accept) begin
            cfg_d = '{ctrl:   i_cfg_ctrl,   thetas: i_cfg_thetas,
                      deltas: i_cfg_deltas, ampls:  i_cfg_ampls,
                      clkdiv: i_cfg_clkdiv, lngth:  i_cfg_lngth};
        end

        case (state)
            IDLE: begin
                if (accept)          state_d = WR_HALT;
                else if (i_stat_req) state_d = STAT_RD;
            end
            WR_HALT: begin
                state_d = WR_REGS;
                idx_d   = IDX_THETAS;
            end
            WR_REGS: begin
                if (idx == IDX_LNGTH) state_d = WR_CTRL;
                else                  idx_d   = next_index(idx);
            end
            WR_CTRL: begin
`ifdef DDS_CFG_VERIFY_EN
                state_d = RD_VERIFY;
                idx_d   = IDX_THETAS;
`else
                state_d = DONE;
`endif
            end
`ifdef DDS_CFG_VERIFY_EN
            RD_VERIFY: begin
                // Verify order ends with CTRL, so LNGTH is followed by index 0.
                if (idx == IDX_CTRL)       state_d = DONE;
                else if (idx == IDX_LNGTH) idx_d   = IDX_CTRL;
                else                       idx_d   = next_index(idx);
            end
`endif
            STAT_RD:  state_d = STAT_RSP;
            STAT_RSP: state_d = IDLE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        case (state_d)
            WR_HALT: begin
                bus_write_d = 1'b1;
                addrs_d     = 32'(IDX_CTRL);
                wdata_d     = cfg_d.ctrl & ~32'd1;
            end
            WR_REGS: begin
                bus_write_d = 1'b1;
                addrs_d     = 32'(idx_d);
                wdata_d     = reg_value(cfg_d, idx_d);
            end
            WR_CTRL: begin
                bus_write_d = 1'b1;
                addrs_d     = 32'(IDX_CTRL);
                wdata_d     = cfg_d.ctrl;
            end
`ifdef DDS_CFG_VERIFY_EN
            RD_VERIFY: begin
                bus_read_d = 1'b1;
                addrs_d    = 32'(idx_d);
            end
`endif
            STAT_RD: begin
                bus_read_d = 1'b1;
                addrs_d    = 32'(IDX_STAT);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            idx             <= IDX_CTRL;
            cfg_q           <= '0;
            o_bus_write     <= 1'b0;
            o_bus_read      <= 1'b0;
            o_bus_addrs     <= '0;
            o_bus_writedata <= '0;
            o_done          <= 1'b0;
            o_stat_valid    <= 1'b0;
            o_stat_data     <= '0;
        end else begin
            state           <= state_d;
            idx             <= idx_d;
            cfg_q           <= cfg_d;
            o_bus_write     <= bus_write_d;
            o_bus_read      <= bus_read_d;
            o_bus_addrs     <= addrs_d;
            o_bus_writedata <= wdata_d;
            o_done          <= (state_d == DONE);
            o_stat_valid    <= (state_d == STAT_RSP);
            if (state == STAT_RD) o_stat_data <= i_bus_readdata[SIG_WIDTH-1:0];
        end
    end

`ifdef DDS_CFG_VERIFY_EN
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            o_err <= 1'b0;
        end else if (state == RD_VERIFY && i_bus_readdata != reg_value(cfg_q, idx)) begin
            o_err <= 1'b1;
        end
    end
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_dds_cfg_initiator.sv
// Scoreboard bench for dds_cfg_initiator; expected bus/done/stat events are queued
// with their cycle numbers and matched by a negedge monitor.
module tb_dds_cfg_initiator;

    localparam int SW = 16;
`ifdef DDS_CFG_VERIFY_EN
    localparam int SEQ = 14;
`else
    localparam int SEQ = 8;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_cfg_valid = 1'b0;
    logic          o_cfg_ready;
    logic [31:0]   i_cfg_ctrl = '0, i_cfg_thetas = '0, i_cfg_deltas = '0;
    logic [31:0]   i_cfg_ampls = '0, i_cfg_clkdiv = '0, i_cfg_lngth = '0;
    logic          i_stat_req = 1'b0;
    logic          o_stat_valid;
    logic [SW-1:0] o_stat_data;
    logic          o_bus_write, o_bus_read;
    logic [31:0]   o_bus_addrs, o_bus_writedata;
    logic [31:0]   i_bus_readdata;
    logic          o_done, o_err;

    dds_cfg_initiator #(.SIG_WIDTH(SW)) dut (
        .clk(clk), .rst(rst),
        .i_cfg_valid(i_cfg_valid), .o_cfg_ready(o_cfg_ready),
        .i_cfg_ctrl(i_cfg_ctrl), .i_cfg_thetas(i_cfg_thetas), .i_cfg_deltas(i_cfg_deltas),
        .i_cfg_ampls(i_cfg_ampls), .i_cfg_clkdiv(i_cfg_clkdiv), .i_cfg_lngth(i_cfg_lngth),
        .i_stat_req(i_stat_req), .o_stat_valid(o_stat_valid), .o_stat_data(o_stat_data),
        .o_bus_write(o_bus_write), .o_bus_read(o_bus_read),
        .o_bus_addrs(o_bus_addrs), .o_bus_writedata(o_bus_writedata),
        .i_bus_readdata(i_bus_readdata), .o_done(o_done), .o_err(o_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          kind;   // 0 write, 1 read, 2 done (data = err), 3 stat (data = sample)
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    ev_t         exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic        mon_en = 1'b0;
    logic        corrupt = 1'b0;
    logic [31:0] stat_val = '0;
    logic [31:0] mem [0:7];

    always @(posedge clk) cyc <= cyc + 1;

    // Register-map responder: zero-latency reads of what was last written.
    always @* begin
        i_bus_readdata = '0;
        if (o_bus_read) begin
            if (o_bus_addrs == 32'd5)                 i_bus_readdata = stat_val;
            else if (corrupt && o_bus_addrs == 32'd3) i_bus_readdata = '0;
            else                                      i_bus_readdata = mem[o_bus_addrs[2:0]];
        end
    end

    task automatic observe(input int kind, input logic [31:0] addr, input logic [31:0] data);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: cyc=%0d kind=%0d addr=%0h data=%0h, required none",
                     cyc, kind, addr, data);
        end else begin
            e = exp_q.pop_front();
            if (e.cyc != cyc || e.kind != kind || e.addr !== addr ||
                (kind != 1 && e.data !== data)) begin
                errors++;
                $display("FAIL event: got cyc=%0d kind=%0d addr=%0h data=%0h, required cyc=%0d kind=%0d addr=%0h data=%0h",
                         cyc, kind, addr, data, e.cyc, e.kind, e.addr, e.data);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (o_bus_write && o_bus_read) begin
                errors++;
                $display("FAIL bus_exclusive: write=%b read=%b, required not both", o_bus_write, o_bus_read);
            end
            if (!o_bus_write && !o_bus_read) begin
                checks++;
                if (o_bus_addrs !== 32'd0 || o_bus_writedata !== 32'd0) begin
                    errors++;
                    $display("FAIL bus_idle_zero: addr=%0h data=%0h, required 0/0", o_bus_addrs, o_bus_writedata);
                end
            end
            if (o_bus_write) begin
                mem[o_bus_addrs[2:0]] = o_bus_writedata;
                observe(0, o_bus_addrs, o_bus_writedata);
            end
            if (o_bus_read)   observe(1, o_bus_addrs, 32'd0);
            if (o_done)       observe(2, 32'd0, {31'd0, o_err});
            if (o_stat_valid) observe(3, 32'd0, 32'(o_stat_data));
        end
    end

    task automatic push(input int c, input int k, input logic [31:0] a, input logic [31:0] d);
        ev_t e;
        e.cyc = c; e.kind = k; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    // v = {ctrl, thetas, deltas, ampls, clkdiv, lngth}; events after 'limit' are not expected.
    task automatic push_cfg(input int n, input logic [31:0] v [6], input logic bad, input int limit);
        int          waddr [6] = '{1, 2, 3, 4, 6, 0};
        logic [31:0] wdat  [6];
        logic        err;
        wdat = '{v[1], v[2], v[3], v[4], v[5], v[0]};
        if (n + 1 <= limit) push(n + 1, 0, 32'd0, v[0] & ~32'd1);
        for (int i = 0; i < 6; i++)
            if (n + 2 + i <= limit) push(n + 2 + i, 0, 32'(waddr[i]), wdat[i]);
        err = 1'b0;
`ifdef DDS_CFG_VERIFY_EN
        for (int i = 0; i < 6; i++)
            if (n + 8 + i <= limit) push(n + 8 + i, 1, 32'(waddr[i]), 32'd0);
        err = bad && (v[3] != 32'd0);
`endif
        if (n + SEQ <= limit) push(n + SEQ, 2, 32'd0, {31'd0, err});
    endtask

    task automatic set_inputs(input logic [31:0] v [6]);
        i_cfg_ctrl = v[0]; i_cfg_thetas = v[1]; i_cfg_deltas = v[2];
        i_cfg_ampls = v[3]; i_cfg_clkdiv = v[4]; i_cfg_lngth = v[5];
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drained: %0d events pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic run_cfg(input logic [31:0] v [6], input logic bad, input string name);
        @(negedge clk);
        push_cfg(cyc, v, bad, 1 << 30);
        set_inputs(v);
        i_cfg_valid = 1'b1;
        @(negedge clk);
        i_cfg_valid = 1'b0;
        repeat (SEQ + 3) @(negedge clk);
        check_drained(name);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if (o_cfg_ready !== 1'b1 || o_bus_write !== 1'b0 || o_bus_read !== 1'b0 ||
            o_bus_addrs !== 32'd0 || o_bus_writedata !== 32'd0 || o_done !== 1'b0 ||
            o_err !== 1'b0 || o_stat_valid !== 1'b0 || o_stat_data !== '0) begin
            errors++;
            $display("FAIL reset_state: rdy=%b wr=%b rd=%b a=%0h d=%0h done=%b err=%b sv=%b sd=%0h, required 1,0,0,0,0,0,0,0,0",
                     o_cfg_ready, o_bus_write, o_bus_read, o_bus_addrs, o_bus_writedata,
                     o_done, o_err, o_stat_valid, o_stat_data);
        end
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        checks++;
        if (o_cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: %b, required 1", o_cfg_ready);
        end
    endtask

    task automatic test_config;
        logic [31:0] v [6] = '{32'h3, 32'h10, 32'h20, 32'h7FFF, 32'd4, 32'd256};
        run_cfg(v, 1'b0, "config");
        v = '{32'hFFFF_FFFE, 32'hDEAD_BEEF, 32'h0, 32'h8000_0001, 32'h1, 32'hFFFF_FFFF};
        run_cfg(v, 1'b0, "config_edge");
        checks++;
        if (o_err !== 1'b0) begin
            errors++;
            $display("FAIL config_err: %b, required 0", o_err);
        end
    endtask

    task automatic test_verify;
        logic [31:0] v [6] = '{32'h3, 32'h10, 32'h20, 32'h7FFF, 32'd4, 32'd256};
        logic exp_err;
`ifdef DDS_CFG_VERIFY_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        corrupt = 1'b1;
        run_cfg(v, 1'b1, "verify_bad");
        corrupt = 1'b0;
        checks++;
        if (o_err !== exp_err) begin
            errors++;
            $display("FAIL verify_err_held: %b, required %b", o_err, exp_err);
        end
        run_cfg(v, 1'b0, "verify_clean");
        checks++;
        if (o_err !== 1'b0) begin
            errors++;
            $display("FAIL verify_err_clean: %b, required 0", o_err);
        end
    endtask

    task automatic test_stat;
        logic [31:0] vals [2] = '{32'hFFFF_8001, 32'h0000_7FFE};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            stat_val = vals[i];
            push(cyc + 1, 1, 32'd5, 32'd0);
            push(cyc + 2, 3, 32'd0, {16'd0, vals[i][15:0]});
            i_stat_req = 1'b1;
            @(negedge clk);
            i_stat_req = 1'b0;
            repeat (4) @(negedge clk);
            check_drained("stat");
        end
    endtask

    task automatic test_simultaneous;
        logic [31:0] v [6] = '{32'h5, 32'h1, 32'h2, 32'h3, 32'h4, 32'h6};
        @(negedge clk);
        stat_val = 32'h1234;
        push_cfg(cyc, v, 1'b0, 1 << 30);
        set_inputs(v);
        i_cfg_valid = 1'b1;
        i_stat_req  = 1'b1;
        @(negedge clk);
        i_cfg_valid = 1'b0;
        i_stat_req  = 1'b0;
        repeat (SEQ + 3) @(negedge clk);
        check_drained("simultaneous");
    endtask

    task automatic test_reset_mid;
        logic [31:0] v [6] = '{32'h3, 32'h11, 32'h22, 32'h33, 32'h44, 32'h66};
        int n;
        @(negedge clk);
        n = cyc;
        push_cfg(n, v, 1'b0, n + 4);
        set_inputs(v);
        i_cfg_valid = 1'b1;
        @(negedge clk);
        i_cfg_valid = 1'b0;
        while (cyc < n + 4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (o_cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_ready: %b, required 1", o_cfg_ready);
        end
        repeat (SEQ + 2) @(negedge clk);
        check_drained("reset_mid");
    endtask

    task automatic test_back_to_back;
        logic [31:0] v [6] = '{32'hA5A5_0001, 32'h100, 32'h200, 32'h300, 32'h400, 32'h600};
        logic [31:0] r [6];
        @(negedge clk);
        push_cfg(cyc, v, 1'b0, 1 << 30);
        set_inputs(v);
        i_cfg_valid = 1'b1;
        for (int k = 1; k <= SEQ; k++) begin
            @(negedge clk);
            checks++;
            if (o_cfg_ready !== 1'b0) begin
                errors++;
                $display("FAIL busy_ready: cycle %0d of sequence ready=%b, required 0", k, o_cfg_ready);
            end
            for (int j = 0; j < 6; j++) r[j] = $urandom;
            set_inputs(r);
            if (k == SEQ) i_cfg_valid = 1'b0;
        end
        repeat (4) @(negedge clk);
        check_drained("back_to_back");
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = '0;
        test_reset;
        test_config;
        test_verify;
        test_stat;
        test_simultaneous;
        test_reset_mid;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dds_cfg_initiator.md
DDS_CFG_INITIATOR -- requirements
Module: dds_cfg_initiator

Interface
REQ-001 Parameter SIG_WIDTH, default 16: width of the DDS sample held in the STAT register.
REQ-002 clk  input  1  sole clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 i_cfg_valid  input  1  configuration request.
REQ-005 o_cfg_ready  output  1  high only in IDLE; accept = i_cfg_valid && o_cfg_ready.
REQ-006 i_cfg_ctrl, i_cfg_thetas, i_cfg_deltas, i_cfg_ampls, i_cfg_clkdiv, i_cfg_lngth  input  32 each  register values, sampled on accept.
REQ-007 i_stat_req  input  1  request one STAT readout.
REQ-008 o_stat_valid  output  1  one-cycle pulse; o_stat_data is valid.
REQ-009 o_stat_data  output  SIG_WIDTH  sign-truncated STAT readout.
REQ-010 o_bus_write, o_bus_read  output  1 each  bus strobes to the register map.
REQ-011 o_bus_addrs, o_bus_writedata  output  32 each  word address and write data.
REQ-012 i_bus_readdata  input  32  zero-latency read data, valid in the same cycle as o_bus_read.
REQ-013 o_done  output  1  one-cycle pulse at end of a configuration sequence.
REQ-014 o_err  output  1  verify mismatch, valid with o_done; held until next accept.

Function
REQ-015 States: IDLE, WR_HALT, WR_REGS, WR_CTRL, RD_VERIFY, STAT_RD, STAT_RSP, DONE.
REQ-016 IDLE: accept -> WR_HALT; else i_stat_req -> STAT_RD; cfg has priority when both are high in the same cycle, and the stat request is dropped.
REQ-017 Accept in cycle N latches all six values; the block ignores input changes after N.
REQ-018 WR_HALT (N+1): write addr 0 (CTRL), data = latched ctrl with bit 0 cleared.
REQ-019 WR_REGS (N+2..N+6): one write per cycle, addresses 1,2,3,4,6 (THETAS, DELTAS, AMPLS, CLKDIV, LNGTH) with the latched data; STAT (5) is never written.
REQ-020 WR_CTRL (N+7): write addr 0, full latched ctrl.
REQ-021 DONE: o_done high for one cycle, then IDLE; with no verify, DONE is at N+8.
REQ-022 o_bus_write and o_bus_read are never both high; when both are low, addrs and writedata are 0.
REQ-023 STAT_RD: o_bus_read=1, addr 5 for one cycle, and i_bus_readdata[SIG_WIDTH-1:0] is registered.
REQ-024 STAT_RSP: o_stat_valid=1 with registered data (one cycle after STAT_RD), then IDLE.
REQ-025 The address index counter is 3 bits; the sequence skips index 5 and terminates at 6 without wrapping.

Reset
REQ-026 rst high at any clock edge: state IDLE, all strobes 0, addrs/writedata 0, o_done/o_err/o_stat_valid 0, o_stat_data 0, latched values 0.
REQ-027 Reset mid-sequence aborts the sequence: no further writes and no o_done; o_cfg_ready is 1 in the first cycle after rst deasserts.

Configuration
REQ-028 Macro DDS_CFG_VERIFY_EN defined: after WR_CTRL, RD_VERIFY reads addrs 1,2,3,4,6,0 (N+8..N+13), comparing each read with the latched value (CTRL compared with full ctrl).
REQ-029 Under DDS_CFG_VERIFY_EN, any mismatch sets o_err, and DONE is at N+14.
REQ-030 Macro undefined: RD_VERIFY is absent, and o_err is tied to 0.

Structure
REQ-031 Package dds_pkg holds the register index constants (CTRL=0, THETAS=1, DELTAS=2, AMPLS=3, CLKDIV=4, STAT=5, LNGTH=6) and the state enum typedef.
REQ-032 There is no sub-module; one FSM with the index counter, bus drive in a single registered process.

Verification
REQ-033 Config: ctrl=0x3, thetas=0x10, deltas=0x20, ampls=0x7FFF, clkdiv=4, lngth=256 -> writes (0,0x2),(1,0x10),(2,0x20),(3,0x7FFF),(4,4),(6,256),(0,0x3) on N+1..N+7; o_done at N+8.
REQ-034 Verify: DDS_CFG_VERIFY_EN on, responder model corrupts the AMPLS readback to 0 -> o_err=1 with o_done at N+14; clean model -> o_err=0.
REQ-035 STAT: i_stat_req in IDLE, responder returns 0xFFFF8001, SIG_WIDTH=16 -> one read of addr 5, o_stat_valid next cycle with o_stat_data=0x8001.
REQ-036 Simultaneous: i_cfg_valid and i_stat_req in the same IDLE cycle -> config sequence runs, no STAT read, o_stat_valid stays 0.
REQ-037 Reset: rst asserted at N+4 -> no strobes from N+5, no o_done, o_cfg_ready=1 the cycle after release.
REQ-038 Backpressure: i_cfg_valid held high with changing data during a sequence -> no second accept until IDLE, and written data equals the values at the original accept.
